// File: rtl/sram_rsp_adapter_if.sv
// sram_rsp_adapter_if
//   Bundles the request stream, the response stream and the SRAM macro
//   signals around sram_rsp_adapter. Signal names keep their original
//   _i/_o suffixes, which describe direction as seen from the adapter.
//   Modports:
//     slave  - the adapter itself
//     master - the environment: requester, response sink and SRAM macro
//   Parameters: AddrWidth, DataWidth, BeWidth.
interface sram_rsp_adapter_if #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BeWidth   = 8
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_wdata_i;
  logic [BeWidth-1:0]   req_be_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 sram_req_o;
  logic                 sram_we_o;
  logic [AddrWidth-1:0] sram_addr_o;
  logic [DataWidth-1:0] sram_wdata_o;
  logic [BeWidth-1:0]   sram_be_o;
  logic [DataWidth-1:0] sram_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  rsp_ready_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output rsp_ready_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/sram_rsp_adapter.sv
// sram_rsp_adapter
//   Front end for a single-port SRAM macro with a fixed read latency.
//   Turns a valid/ready request stream into the macro's req/we strobes,
//   tracks reads across the macro latency and lands the returned data in a
//   response FIFO. A request that produces a response is only admitted when
//   a FIFO slot is guaranteed for it (credits), so back-pressure on the
//   response side never drops data.
//   Ports:
//     clk_i  - clock
//     rst_i  - asynchronous, active-high reset
//     bus    - sram_rsp_adapter_if.slave: req_* stream in, rsp_* stream
//              out, sram_* macro drive and sram_rdata_i return data
//   Optional feature macro SRAM_RSP_ADAPTER_WRITE_RSP_EN: writes are
//   credit-checked and return an in-order acknowledge with zero data.
module sram_rsp_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned Depth     = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  sram_rsp_adapter_if.slave bus
);
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
  localparam int unsigned CntWidth  = $clog2(Depth + 1);
  localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;

  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "sram_rsp_adapter: Latency must be at least 1");
  end
  if (Depth < Latency + 1) begin : g_bad_depth
    $fatal(1, "sram_rsp_adapter: Depth must be at least Latency + 1");
  end

  logic [Latency-1:0]   inflight_q, inflight_d;
  logic [CntWidth-1:0]  inflight_cnt, fifo_cnt_q;
  logic [CntWidth:0]    committed;
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] push_data;
  logic [AddrWidth-1:0] sram_addr;
  logic [BeWidth-1:0]   sram_be;
  logic req_ready, accept, track, needs_credit, credit_ok;
  logic push, pop, rsp_valid;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

`ifdef SRAM_RSP_ADAPTER_WRITE_RSP_EN
  // Parallel tag pipeline: marks which tracked slot is a write acknowledge.
  logic [Latency-1:0] is_wr_q, is_wr_d;

  assign needs_credit = 1'b1;
  assign track        = accept;
  assign push_data    = is_wr_q[Latency-1] ? '0 : bus.sram_rdata_i;

  if (Latency == 1) begin : g_wr_sh1
    assign is_wr_d = accept & bus.req_we_i;
  end else begin : g_wr_shn
    assign is_wr_d = {is_wr_q[Latency-2:0], accept & bus.req_we_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) is_wr_q <= '0;
    else       is_wr_q <= is_wr_d;
  end
`else
  assign needs_credit = ~bus.req_we_i;
  assign track        = accept & ~bus.req_we_i;
  assign push_data    = bus.sram_rdata_i;
`endif

  if (Latency == 1) begin : g_sh1
    assign inflight_d = track;
  end else begin : g_shn
    assign inflight_d = {inflight_q[Latency-2:0], track};
  end

  always_comb begin
    inflight_cnt = '0;
    for (int unsigned i = 0; i < Latency; i++) begin
      inflight_cnt = inflight_cnt + CntWidth'(inflight_q[i]);
    end
  end

  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid & bus.rsp_ready_i;
  assign push      = inflight_q[Latency-1];

  // Slots already promised: tracked requests plus buffered responses, minus
  // the one leaving this cycle. This makes rsp_ready_i -> req_ready_o
  // combinational so a full pipeline keeps streaming at one per cycle.
  assign committed = {1'b0, inflight_cnt} + {1'b0, fifo_cnt_q}
                   - {{CntWidth{1'b0}}, pop};
  assign credit_ok = committed < (CntWidth + 1)'(Depth);
  assign req_ready = ~rst_i & (~needs_credit | credit_ok);
  assign accept    = bus.req_valid_i & req_ready;

  assign sram_addr = bus.req_addr_i;
  assign sram_be   = bus.req_be_i;

  assign bus.req_ready_o  = req_ready;
  assign bus.sram_req_o   = accept;
  assign bus.sram_we_o    = bus.req_we_i;
  assign bus.sram_addr_o  = sram_addr;
  assign bus.sram_wdata_o = bus.req_wdata_i;
  assign bus.sram_be_o    = sram_be;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_rdata_o  = rsp_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntWidth'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntWidth'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the output is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (fifo_cnt_q == CntWidth'(Depth))))
    else $error("sram_rsp_adapter: push into full response FIFO");

endmodule

// File: tb/tb_sram_rsp_adapter.sv
// tb_sram_rsp_adapter
//   Randomised and directed stimulus around sram_rsp_adapter (Latency=2,
//   Depth=3) with a behavioural SRAM, a reference memory and a response
//   scoreboard checked by an independent monitor.
module tb_sram_rsp_adapter;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 3;
  localparam int unsigned NW  = 64;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 64;
  localparam int unsigned BEW = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   n_pops = 0;
  bit   exact_lat = 1'b0;
  int   rdy_mode = 0;   // 0 hold rdy_fixed, 1 toggle, 2 random
  bit   rdy_fixed = 1'b1;
  exp_t sb_q[$];

  logic [DW-1:0] ref_mem  [NW];
  logic [DW-1:0] sram_mem [NW];
  logic [DW-1:0] pipe     [LAT];

  sram_rsp_adapter_if #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BEW)) bus ();

  sram_rsp_adapter #(
    .NumWords (NW),
    .DataWidth(DW),
    .ByteWidth(8),
    .Latency  (LAT),
    .Depth    (DEP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] wd,
                                          input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BEW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'(i * 7 + 3)};
  endfunction

  // Behavioural SRAM macro with LAT-cycle read latency; junk when idle.
  always @(posedge clk) begin
    if (bus.sram_req_o && bus.sram_we_o)
      sram_mem[bus.sram_addr_o] <= merge(sram_mem[bus.sram_addr_o], bus.sram_wdata_o, bus.sram_be_o);
    pipe[0] <= (bus.sram_req_o && !bus.sram_we_o) ? sram_mem[bus.sram_addr_o] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.sram_rdata_i = pipe[LAT-1];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response ready driver.
  initial begin
    bus.rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        1:       bus.rsp_ready_i = ~bus.rsp_ready_i;
        2:       bus.rsp_ready_i = 1'($urandom_range(0, 1));
        default: bus.rsp_ready_i = rdy_fixed;
      endcase
    end
  end

  // Scoreboard producer: every accepted request updates the reference.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst && bus.req_valid_i && bus.req_ready_o) begin
        if (bus.req_we_i) begin
          ref_mem[bus.req_addr_i] = merge(ref_mem[bus.req_addr_i], bus.req_wdata_i, bus.req_be_i);
`ifdef SRAM_RSP_ADAPTER_WRITE_RSP_EN
          sb_q.push_back('{data: '0, acc: cyc});
`endif
        end else begin
          sb_q.push_back('{data: ref_mem[bus.req_addr_i], acc: cyc});
        end
      end
    end
  end

  // Monitor: compares every consumed response against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
        n_pops++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %h, expected no response (cycle %0d)", bus.rsp_rdata_o, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", bus.rsp_rdata_o, e.data);
          if (exact_lat) chk("rsp_latency", 64'(cyc - e.acc), 64'(LAT + 1));
          else begin
            checks++;
            if (cyc - e.acc < int'(LAT + 1)) begin
              errors++;
              $display("FAIL rsp_too_early: got latency %0d expected at least %0d", cyc - e.acc, LAT + 1);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
  endtask

  task automatic do_req(input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [BEW-1:0] be);
    bit ok;
    ok = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_wdata_i = wd;
    bus.req_be_i    = be;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) ok = 1'b1;
      else stalls++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no accept, expected accept within 200 cycles (addr %h)", a);
    end
  endtask

  task automatic drain();
    idle();
    rdy_mode  = 0;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int idx;
    for (int i = 0; i < int'(NW); i++) begin
      ref_mem[i]  = init_word(i);
      sram_mem[i] = init_word(i);
    end
    for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;
    bus.req_valid_i = 1'b1;   // held high so the reset gating is visible
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '1;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_sram_req",  64'(bus.sram_req_o),  64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o,      64'd0);
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk); #1;

    // Back-to-back reads, ready held high: exact latency and no stalls.
    exact_lat = 1'b1;
    stalls    = 0;
    do_req(1'b0, 6'h10, '0, '1);
    do_req(1'b0, 6'h11, '0, '1);
    idle();
    drain();
    exact_lat = 1'b0;
    chk("b2b_no_stall", 64'(stalls), 64'd0);

    // Back-pressure: exactly DEP reads admitted while responses are held.
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idx = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = AW'(idx);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) idx++;
      @(posedge clk); #1;
      bus.req_addr_i = AW'(idx);
    end
    chk("bp_accepts", 64'(idx), 64'(DEP));
    @(negedge clk);
    chk("bp_ready_low", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk); #1;
    rdy_fixed = 1'b1;
    while (idx < 6) begin
      do_req(1'b0, AW'(idx), '0, '1);
      idx++;
    end
    drain();

    // Write then read of the same word.
    do_req(1'b1, 6'd5, 64'hDEAD_BEEF, 8'hFF);
    do_req(1'b0, 6'd5, '0, '1);
    idle();
    drain();
    chk("wr_rd_ref", ref_mem[5], 64'hDEAD_BEEF);

    // Write presented while the response FIFO is full.
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 6'd30;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 6'd7;
    bus.req_wdata_i = 64'h0123_4567_89AB_CDEF;
    bus.req_be_i    = 8'h0F;
    @(negedge clk);
`ifdef SRAM_RSP_ADAPTER_WRITE_RSP_EN
    chk("full_wr_ready", 64'(bus.req_ready_o), 64'd0);
    chk("full_wr_sram_req", 64'(bus.sram_req_o), 64'd0);
`else
    chk("full_wr_ready", 64'(bus.req_ready_o), 64'd1);
    chk("full_wr_sram_req", 64'(bus.sram_req_o), 64'd1);
`endif
    chk("full_wr_sram_we", 64'(bus.sram_we_o), 64'd1);
    chk("full_wr_sram_addr", 64'(bus.sram_addr_o), 64'd7);
    @(posedge clk); #1;
    idle();
    drain();

    // Wrap-around with toggling response ready.
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) do_req(1'b0, AW'($urandom_range(0, NW - 1)), '0, '1);
    idle();
    drain();

    // Reset while two reads are in flight.
    do_req(1'b0, 6'd20, '0, '1);
    do_req(1'b0, 6'd21, '0, '1);
    rst = 1'b1;
    sb_q.delete();
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("midrst_sram_req",  64'(bus.sram_req_o),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    idx = n_pops;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 64'(n_pops - idx), 64'd0);
    do_req(1'b0, 6'd22, '0, '1);
    idle();
    drain();

    // Randomised mix of reads, writes and idle cycles.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end else begin
        do_req(($urandom_range(0, 9) < 3), AW'($urandom_range(0, NW - 1)),
               {$urandom, $urandom}, BEW'($urandom));
      end
    end
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
